// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered 8-to-3 request encoder.
// Both the top level and the rotating picker import this package.
package enc_pkg;

  localparam int N = 8;
  localparam int W = 3;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Number of set bits in an 8-bit request vector.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: the first set bit of a, searching from index start
// downward and wrapping from 0 to 7.
module rr_pick
  import enc_pkg::*;
(
  input  logic [N-1:0] a,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_pe;

  // w_rot[7] holds a[start], w_rot[6] holds a[start-1], and so on.
  for (genvar j = 0; j < N; j++) begin : g_rot
    assign w_rot[j] = a[W'(start + W'(j + 1))];
  end

  always_comb begin
    w_pe = '0;
    for (int j = 0; j < N; j++) begin
      if (w_rot[j]) begin
        w_pe = W'(j);
      end
    end
  end

  assign idx = W'(start + W'(1) + w_pe);
  assign any = |a;

endmodule

// File: rtl/rr_encoder_8x3.sv
// Registered 8-to-3 encoder with fixed-priority or round-robin selection,
// multi-hot and all-zero flags, and valid/ready handshakes on both sides.
module rr_encoder_8x3
  import enc_pkg::*;
#(
  parameter int MODE = MODE_RR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         multi,
  output logic         zero,
  output logic [W-1:0] o_dbg_ptr
);

  // Handshake: a beat moves on a side when its valid and ready are both high in
  // the same cycle. in_ready opens whenever the output slot is empty or drains now.

  logic [W-1:0] r_b;
  logic         r_out_valid;
  logic         r_multi;
  logic         r_zero;
  logic [W-1:0] r_ptr;

  logic         w_accept;
  logic [W-1:0] w_start;
  logic [W-1:0] w_idx;
  logic         w_any;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Fixed priority is round-robin with the search permanently starting at bit 7.
  assign w_start = (MODE == MODE_RR) ? r_ptr : W'(N - 1);

  rr_pick u_pick (
    .a     (a),
    .start (w_start),
    .idx   (w_idx),
    .any   (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_b         <= '0;
      r_multi     <= 1'b0;
      r_zero      <= 1'b0;
      r_ptr       <= W'(N - 1);
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_b         <= w_any ? w_idx : '0;
      r_multi     <= popcount8(a) > 4'd1;
      r_zero      <= !w_any;
      if (MODE == MODE_RR && w_any) begin
        r_ptr <= W'(w_idx - W'(1));
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign b         = r_b;
  assign out_valid = r_out_valid;
  assign multi     = r_multi;
  assign zero      = r_zero;
  assign o_dbg_ptr = r_ptr;

endmodule

// File: tb/tb_rr_encoder_8x3.sv
// Directed bench for rr_encoder_8x3: a round-robin and a fixed-priority
// instance share one set of inputs and are checked against hand-computed values.
module tb_rr_encoder_8x3;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic       in_valid;
  logic       out_ready;

  logic       rr_in_ready, rr_out_valid, rr_multi, rr_zero;
  logic [2:0] rr_b, rr_ptr;
  logic       fx_in_ready, fx_out_valid, fx_multi, fx_zero;
  logic [2:0] fx_b, fx_ptr;

  int n_cmp;
  int n_err;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_encoder_8x3 #(.MODE(1)) dut_rr (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .in_valid  (in_valid),
    .in_ready  (rr_in_ready),
    .b         (rr_b),
    .out_valid (rr_out_valid),
    .out_ready (out_ready),
    .multi     (rr_multi),
    .zero      (rr_zero),
    .o_dbg_ptr (rr_ptr)
  );

  rr_encoder_8x3 #(.MODE(0)) dut_fx (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .in_valid  (in_valid),
    .in_ready  (fx_in_ready),
    .b         (fx_b),
    .out_valid (fx_out_valid),
    .out_ready (out_ready),
    .multi     (fx_multi),
    .zero      (fx_zero),
    .o_dbg_ptr (fx_ptr)
  );

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] av, input logic vld, input logic rdy);
    a         = av;
    in_valid  = vld;
    out_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b1);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops the next expected round-robin index and compares it with b.
  task automatic chk_rr_b(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {5'd0, rr_b}, e);
    end
  endtask

  function automatic logic [7:0] dec3x8(input logic [2:0] idx);
    logic [7:0] one;
    one = 8'h01;
    return one << idx;
  endfunction

  // ---------------- directed steps ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(8'h00, 1'b0, 1'b1);

    // Reset state
    do_reset();
    chk("rst_out_valid", {7'd0, rr_out_valid}, 8'h00);
    chk("rst_b",         {5'd0, rr_b},         8'h00);
    chk("rst_multi",     {7'd0, rr_multi},     8'h00);
    chk("rst_zero",      {7'd0, rr_zero},      8'h00);
    chk("rst_in_ready",  {7'd0, rr_in_ready},  8'h01);
    chk("rst_ptr",       {5'd0, rr_ptr},       8'h07);

    // One-hot sweep, decoder loop-back
    for (int i = 0; i < 8; i++) begin
      drive(dec3x8(3'(i)), 1'b1, 1'b1);
      exp_q.push_back(8'(i));
      cyc();
      chk_rr_b("onehot_rr_b");
      chk("onehot_fx_b",   {5'd0, fx_b},         8'(i));
      chk("onehot_valid",  {7'd0, rr_out_valid}, 8'h01);
      chk("onehot_multi",  {7'd0, rr_multi},     8'h00);
      chk("onehot_zero",   {7'd0, rr_zero},      8'h00);
      chk("onehot_loop",   dec3x8(rr_b),         dec3x8(3'(i)));
    end
    drive(8'h00, 1'b0, 1'b1);
    cyc();
    chk("drain_valid", {7'd0, rr_out_valid}, 8'h00);

    // Fixed priority patterns
    drive(8'b1010_0110, 1'b1, 1'b1);
    cyc();
    chk("fx_a6_b",     {5'd0, fx_b},     8'h07);
    chk("fx_a6_multi", {7'd0, fx_multi}, 8'h01);
    drive(8'b0000_0110, 1'b1, 1'b1);
    cyc();
    chk("fx_06_b",     {5'd0, fx_b},     8'h02);
    chk("fx_06_multi", {7'd0, fx_multi}, 8'h01);
    chk("fx_ptr",      {5'd0, fx_ptr},   8'h07);

    // Round-robin over all-ones from a fresh pointer
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(8'((15 - i) % 8));
    end
    for (int i = 0; i < 9; i++) begin
      drive(8'hFF, 1'b1, 1'b1);
      cyc();
      chk_rr_b("rr_ff_b");
      chk("rr_ff_multi", {7'd0, rr_multi}, 8'h01);
    end

    // Pointer is 6 here; 0x11 alternates 4,0,4 and leaves it at 3
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd4);
    for (int i = 0; i < 3; i++) begin
      drive(8'b0001_0001, 1'b1, 1'b1);
      cyc();
      chk_rr_b("rr_11_b");
    end
    drive(8'h00, 1'b1, 1'b1);
    cyc();
    chk("rr_zero_flag",  {7'd0, rr_zero},  8'h01);
    chk("rr_zero_b",     {5'd0, rr_b},     8'h00);
    chk("rr_zero_multi", {7'd0, rr_multi}, 8'h00);
    chk("rr_zero_ptr",   {5'd0, rr_ptr},   8'h03);
    drive(8'hFF, 1'b1, 1'b1);
    cyc();
    chk("rr_after_zero_b", {5'd0, rr_b}, 8'h03);

    // Backpressure: result b=3 held while a keeps changing
    for (int i = 0; i < 4; i++) begin
      drive(dec3x8(3'(i)), 1'b1, 1'b0);
      #1;
      chk("bp_in_ready", {7'd0, rr_in_ready}, 8'h00);
      cyc();
      chk("bp_b",     {5'd0, rr_b},         8'h03);
      chk("bp_valid", {7'd0, rr_out_valid}, 8'h01);
      chk("bp_ptr",   {5'd0, rr_ptr},       8'h02);
    end
    drive(8'h10, 1'b1, 1'b1);
    #1;
    chk("bp_release_ready", {7'd0, rr_in_ready}, 8'h01);
    cyc();
    chk("bp_next_b",     {5'd0, rr_b},         8'h04);
    chk("bp_next_valid", {7'd0, rr_out_valid}, 8'h01);
    drive(8'h00, 1'b0, 1'b1);
    cyc();
    chk("bp_drain_valid", {7'd0, rr_out_valid}, 8'h00);

    // Reset while a result is stalled
    drive(8'h02, 1'b1, 1'b0);
    cyc();
    chk("pre_rst_valid", {7'd0, rr_out_valid}, 8'h01);
    chk("pre_rst_b",     {5'd0, rr_b},         8'h01);
    chk("pre_rst_ptr",   {5'd0, rr_ptr},       8'h00);
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    chk("mid_rst_valid", {7'd0, rr_out_valid}, 8'h00);
    chk("mid_rst_ptr",   {5'd0, rr_ptr},       8'h07);
    drive(8'hFF, 1'b1, 1'b1);
    cyc();
    chk("post_rst_b", {5'd0, rr_b}, 8'h07);
    chk("post_rst_fx_ptr", {5'd0, fx_ptr}, 8'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
